cmd_seq_tx: RTL
===============

Name: cmd_seq_tx

Overview:
Parametrised command sequencer, successor to the fixed 5-bit/4-bit ROM-to-UART sender. On a send request it streams cmd_len bytes from a synchronous command ROM to an external UART transmitter, one byte per tx_done. It then waits for a configurable response byte, with a cycle-count timeout. It sits between the host control FSM, the command ROM and the UART; the ROM and UART are external, connected by port handshakes.

Parameters:
ADDR_W, 5, ROM address width; addresses wrap modulo 2^ADDR_W
LEN_W, 4, width of cmd_len
DATA_W, 8, byte width of ROM data, tx_data and rx_data
RESP_BYTE, 8'h0A, response value that completes a command
TIMEOUT_CYC, 1000000, cycles allowed in RESP_WAIT before timeout (>=2)
MAX_RETRY, 2, resend attempts after timeout (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active low
send  in  1  start request, sampled only in IDLE
cmd_start  in  ADDR_W  first ROM address, latched on accepted send
cmd_len  in  LEN_W  byte count, latched on accepted send
rom_addr  out  ADDR_W  registered ROM address
rom_dout  in  DATA_W  ROM data, valid one cycle after rom_addr changes
trmt  out  1  one-cycle UART transmit strobe
tx_data  out  DATA_W  registered byte to transmit, stable while trmt=1
tx_done  in  1  UART byte-complete (pulse or level)
rx_rdy  in  1  UART received-byte valid
rx_data  in  DATA_W  UART received byte
clr_rx_rdy  out  1  one-cycle acknowledge of rx_rdy
busy  out  1  high from accepted send until return to IDLE
resp_rcvd  out  1  one-cycle pulse on matching response
timeout  out  1  one-cycle pulse on final timeout

Behaviour:
- Clock: clk. Reset: rst_n, asynchronous, active low.
- Reset values: every output is 0; state is IDLE; internal counters are 0. Asserting reset mid-operation aborts immediately. No partial trmt is issued after reset.
- Registered Moore outputs: trmt, clr_rx_rdy, resp_rcvd, timeout, busy.
- IDLE:
  - send=1 and cmd_len!=0: latch cmd_start/cmd_len, rom_addr<=cmd_start, remaining<=cmd_len, busy<=1, go to FETCH.
  - send=1 and cmd_len==0: ignored.
- FETCH (1 cycle, ROM latency): tx_data<=rom_dout, go to XMIT.
- XMIT (1 cycle): trmt=1; rom_addr<=rom_addr+1 with wrap (2^ADDR_W-1 -> 0); remaining decrements; go to WAIT_TX.
- Latency: trmt is high in the 3rd cycle after the edge that samples send.
- WAIT_TX:
  - tx_done is ignored in the first WAIT_TX cycle, so a stale level does not count.
  - Thereafter, on tx_done=1: if remaining!=0 go to FETCH, else clear the timer and go to RESP_WAIT.
- RESP_WAIT:
  - The timer increments every cycle.
  - On rx_rdy=1: clr_rx_rdy pulses the next cycle. rx_rdy is ignored in the cycle clr_rx_rdy is high.
  - rx_data==RESP_BYTE: resp_rcvd pulse, go to IDLE.
  - Any other byte is discarded and waiting continues; the timer is not reset.
  - Timer reaches TIMEOUT_CYC-1 with no match: timeout pulse, go to IDLE.
  - If a match and the timeout occur in the same cycle, the match wins.
- send while busy is ignored and not queued.
- rx bytes arriving outside RESP_WAIT are not acknowledged and stay pending for the UART.
- Exactly cmd_len trmt pulses per attempt; cmd_len = 2^LEN_W-1 is the maximum.

Optional Feature:
CMD_SEQ_RETRY_EN
- Defined: on timeout with retry_cnt<MAX_RETRY, no timeout pulse. Instead retry_cnt++, rom_addr<=latched cmd_start, remaining<=latched cmd_len, go to FETCH and resend the whole command. timeout pulses only after MAX_RETRY failed retries. retry_cnt clears on accepted send. A 2-bit retry_cnt output reports it.
- Undefined: first timeout terminates the command; no retry_cnt logic or port.

Decomposition:
- Package cmd_seq_pkg: state enum (IDLE, FETCH, XMIT, WAIT_TX, RESP_WAIT) and the default RESP_BYTE/TIMEOUT_CYC localparams.
- One sub-module, cmd_seq_timer: clearable up-counter sized $clog2(TIMEOUT_CYC), with an expired flag.

Test Plan:
- cmd_start=5'd3, cmd_len=4, ROM[3..6]=A1..A4, tx_done 10 cycles after each trmt -> 4 trmt pulses with tx_data A1,A2,A3,A4; first trmt 3 cycles after send; rom_addr ends at 7.
- Wrap: cmd_start=5'd30, cmd_len=3 -> rom_addr sequence 30,31,0; bytes ROM[30],ROM[31],ROM[0].
- Response: after last tx_done, rx_data=8'h55 then 8'h0A -> two clr_rx_rdy pulses; resp_rcvd once, after 0A only; busy falls the same cycle.
- Timeout: TIMEOUT_CYC=20, no rx_rdy -> timeout pulse at cycle 20 of RESP_WAIT; with CMD_SEQ_RETRY_EN and MAX_RETRY=2, 3x cmd_len trmt pulses total and then timeout.
- Edge cases: cmd_len=0 send -> busy stays 0; second send mid-stream -> ignored, byte count unchanged; tx_done held high from before trmt -> no skipped byte.
- rst_n low during WAIT_TX -> all outputs 0 immediately; a new send afterwards restarts cleanly from cmd_start.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// Shared types and default constants for the command sequencer.
// The top level has an optional resend-on-timeout mode, enabled by defining CMD_SEQ_RETRY_EN.
package cmd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    XMIT      = 3'd2,
    WAIT_TX   = 3'd3,
    RESP_WAIT = 3'd4
  } state_t;

  localparam logic [7:0] DEF_RESP_BYTE   = 8'h0A;
  localparam int         DEF_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/cmd_seq_timer.sv
// Response timer: a clearable up-counter that stops at TIMEOUT_CYC-1 and reports
// that value through the expired flag.
module cmd_seq_timer
  import cmd_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // The counter holds at LAST so that expired stays asserted until the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/cmd_seq_tx.sv
// Command sequencer: streams cmd_len ROM bytes to a UART and then waits for a response byte or a timeout.
// Optional CMD_SEQ_RETRY_EN: a timeout resends the whole command up to MAX_RETRY times.
module cmd_seq_tx
  import cmd_seq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] RESP_BYTE = DATA_W'(DEF_RESP_BYTE),
`ifdef CMD_SEQ_RETRY_EN
  parameter int MAX_RETRY = 2,
`endif
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send,
  input  logic [ADDR_W-1:0] cmd_start,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              trmt,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  input  logic              rx_rdy,
  input  logic [DATA_W-1:0] rx_data,
  output logic              clr_rx_rdy,
  output logic              busy,
  output logic              resp_rcvd,
  output logic              timeout
`ifdef CMD_SEQ_RETRY_EN
  ,
  output logic [1:0]        retry_cnt
`endif
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rom_addr_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic [DATA_W-1:0] tx_data_nxt;
  logic              trmt_nxt, clr_rx_rdy_nxt, busy_nxt, resp_rcvd_nxt, timeout_nxt;
  logic              timer_clr, timer_en, expired;
  logic              rx_take, rx_match;

`ifdef CMD_SEQ_RETRY_EN
  logic [ADDR_W-1:0] start_q, start_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [1:0]        retry_cnt_nxt;

  function automatic logic [1:0] retry_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction
`endif

  cmd_seq_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(expired)
  );

  assign timer_en = (state == RESP_WAIT);
  // The cycle that carries clr_rx_rdy still sees the old rx_rdy level, so it is skipped.
  assign rx_take  = rx_rdy && !clr_rx_rdy;
  assign rx_match = rx_take && (rx_data == RESP_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      remaining  <= '0;
      tx_data    <= '0;
      trmt       <= 1'b0;
      clr_rx_rdy <= 1'b0;
      busy       <= 1'b0;
      resp_rcvd  <= 1'b0;
      timeout    <= 1'b0;
`ifdef CMD_SEQ_RETRY_EN
      start_q    <= '0;
      len_q      <= '0;
      retry_cnt  <= 2'd0;
`endif
    end else begin
      rom_addr   <= rom_addr_nxt;
      remaining  <= remaining_nxt;
      tx_data    <= tx_data_nxt;
      trmt       <= trmt_nxt;
      clr_rx_rdy <= clr_rx_rdy_nxt;
      busy       <= busy_nxt;
      resp_rcvd  <= resp_rcvd_nxt;
      timeout    <= timeout_nxt;
`ifdef CMD_SEQ_RETRY_EN
      start_q    <= start_nxt;
      len_q      <= len_nxt;
      retry_cnt  <= retry_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    rom_addr_nxt   = rom_addr;
    remaining_nxt  = remaining;
    tx_data_nxt    = tx_data;
    trmt_nxt       = 1'b0;
    clr_rx_rdy_nxt = 1'b0;
    busy_nxt       = busy;
    resp_rcvd_nxt  = 1'b0;
    timeout_nxt    = 1'b0;
    timer_clr      = 1'b0;
`ifdef CMD_SEQ_RETRY_EN
    start_nxt      = start_q;
    len_nxt        = len_q;
    retry_cnt_nxt  = retry_cnt;
`endif

    case (state)
      IDLE: begin
        if (send && (cmd_len != '0)) begin
          rom_addr_nxt  = cmd_start;
          remaining_nxt = cmd_len;
          busy_nxt      = 1'b1;
          state_nxt     = FETCH;
`ifdef CMD_SEQ_RETRY_EN
          start_nxt     = cmd_start;
          len_nxt       = cmd_len;
          retry_cnt_nxt = 2'd0;
`endif
        end
      end

      // The ROM registers rom_addr at the end of this cycle.
      FETCH: begin
        state_nxt = XMIT;
      end

      // rom_dout now holds the byte for the address presented in FETCH.
      XMIT: begin
        tx_data_nxt   = rom_dout;
        trmt_nxt      = 1'b1;
        rom_addr_nxt  = rom_addr + ADDR_W'(1);
        remaining_nxt = remaining - LEN_W'(1);
        state_nxt     = WAIT_TX;
      end

      // trmt is high only in the first WAIT_TX cycle; using it as a mask
      // keeps a tx_done level that is still high from the previous byte from counting.
      WAIT_TX: begin
        if (tx_done && !trmt) begin
          if (remaining != '0) begin
            state_nxt = FETCH;
          end else begin
            timer_clr = 1'b1;
            state_nxt = RESP_WAIT;
          end
        end
      end

      RESP_WAIT: begin
        if (rx_take) begin
          clr_rx_rdy_nxt = 1'b1;
        end
        if (rx_match) begin
          resp_rcvd_nxt = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end else if (expired) begin
`ifdef CMD_SEQ_RETRY_EN
          if (int'(retry_cnt) < MAX_RETRY) begin
            retry_cnt_nxt = retry_inc(retry_cnt);
            rom_addr_nxt  = start_q;
            remaining_nxt = len_q;
            state_nxt     = FETCH;
          end else begin
            timeout_nxt = 1'b1;
            busy_nxt    = 1'b0;
            state_nxt   = IDLE;
          end
`else
          timeout_nxt = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
`endif
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
